// File: rtl/mp_acc16_pkg.sv
// ---------------------------------------------------------------------------
// mp_acc16_pkg
// Shared definitions for the multi-precision accumulator stage:
//   - datapath widths (word width, accumulator depth, index width)
//   - operation encodings OP_MOV/OP_NEG/OP_ADD/OP_SUB
//   - FSM state encodings ST_IDLE/ST_RUN/ST_DONE
//   - flag bit positions within the {Z,N,C,V} flag vector
//   - adder control payload and the OP -> adder control mapping
// ---------------------------------------------------------------------------
package mp_acc16_pkg;

   localparam int unsigned WORD_W = 16;
   localparam int unsigned NWORDS = 4;
   localparam int unsigned IDX_W  = 2;
   localparam int unsigned OP_W   = 2;
   localparam int unsigned FLAG_W = 4;

   localparam logic [OP_W-1:0] OP_MOV = 2'd0;
   localparam logic [OP_W-1:0] OP_NEG = 2'd1;
   localparam logic [OP_W-1:0] OP_ADD = 2'd2;
   localparam logic [OP_W-1:0] OP_SUB = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int unsigned F_Z = 3;
   localparam int unsigned F_N = 2;
   localparam int unsigned F_C = 1;
   localparam int unsigned F_V = 0;

   // Adder controls: ena selects A (else 0), sub inverts B.
   typedef struct packed {
      logic ena;
      logic sub;
   } add_ctrl_t;

   function automatic add_ctrl_t op_to_ctrl(input logic [OP_W-1:0] op);
      add_ctrl_t ctrl;
      ctrl.ena = (op == OP_ADD) || (op == OP_SUB);
      ctrl.sub = (op == OP_NEG) || (op == OP_SUB);
      return ctrl;
   endfunction

endpackage

// File: rtl/addsubmovneg16a.sv
// ---------------------------------------------------------------------------
// addsubmovneg16a
// 16-bit add/sub/mov/neg adder: y = (ena ? a : 0) + (sub ? ~b : b) + ci.
// Ports:
//   a   in  16  A operand (gated by ena)
//   b   in  16  B operand (inverted when sub)
//   ci  in  1   carry in
//   ena in  1   enable A operand
//   sub in  1   invert B operand
//   y   out 16  sum
//   co  out 1   carry out
// ---------------------------------------------------------------------------
module addsubmovneg16a (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        ci,
   input  logic        ena,
   input  logic        sub,
   output logic [15:0] y,
   output logic        co
);

   localparam int unsigned W = 16;

   logic [W-1:0] a_eff;
   logic [W-1:0] b_eff;
   logic [W:0]   sum;

   assign a_eff = ena ? a : '0;
   assign b_eff = sub ? ~b : b;
   assign sum   = (W+1)'(a_eff) + (W+1)'(b_eff) + (W+1)'(ci);
   assign y     = sum[W-1:0];
   assign co    = sum[W];

endmodule

// File: rtl/mp_acc16.sv
// ---------------------------------------------------------------------------
// mp_acc16
// Multi-precision accumulator stage around addsubmovneg16a. Holds a 4x16
// accumulator, processes one 16-bit word per cycle LSW first with the carry
// chained through a register, and reports {Z,N,C,V} for the whole operand.
// Ports:
//   clk      in  1   system clock
//   rstn     in  1   asynchronous active-low reset
//   start    in  1   begin an operation (sampled in IDLE only)
//   op       in  2   0 MOV, 1 NEG, 2 ADD, 3 SUB
//   words    in  2   operand length in words minus 1
//   din      in  16  B operand word
//   din_vld  in  1   din valid
//   din_rdy  out 1   word accepted when din_vld is high
//   raddr    in  2   accumulator readback select
//   rdata    out 16  combinational ACC[raddr]
//   busy     out 1   not in IDLE
//   flg_vld  out 1   one-cycle pulse when flags update
//   flags    out 4   {Z,N,C,V}, held between operations
// ---------------------------------------------------------------------------
module mp_acc16
   import mp_acc16_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [OP_W-1:0]   op,
   input  logic [IDX_W-1:0]  words,
   input  logic [WORD_W-1:0] din,
   input  logic              din_vld,
   output logic              din_rdy,
   input  logic [IDX_W-1:0]  raddr,
   output logic [WORD_W-1:0] rdata,
   output logic              busy,
   output logic              flg_vld,
   output logic [FLAG_W-1:0] flags
);

   state_e              state_q;
   state_e              state_d;

   logic [WORD_W-1:0]   acc_q [NWORDS];
   add_ctrl_t           ctrl_q;
   logic [IDX_W-1:0]    last_q;
   logic [IDX_W-1:0]    idx_q;
   logic                carry_q;
   logic                zacc_q;

   logic                din_rdy_q;
   logic                busy_q;
   logic                flg_vld_q;
   logic [FLAG_W-1:0]   flags_q;

   logic                din_rdy_d;
   logic                busy_d;
   logic                flg_vld_d;
   logic [FLAG_W-1:0]   flags_d;

   logic                start_c;
   logic                take_c;
   logic                last_c;
   logic [WORD_W-1:0]   a_c;
   logic [WORD_W-1:0]   y_c;
   logic                co_c;
   logic                a_msb_c;
   logic                b_msb_c;

   // Handshake decode: start only counts in IDLE, words only in RUN.
   assign start_c = (state_q == ST_IDLE) && start;
   assign take_c  = (state_q == ST_RUN) && din_vld;
   assign last_c  = take_c && (idx_q == last_q);

   assign a_c = acc_q[idx_q];

   // CI comes from the carry register only; CO never loops back in-cycle.
   addsubmovneg16a u_add (
      .a   (a_c),
      .b   (din),
      .ci  (carry_q),
      .ena (ctrl_q.ena),
      .sub (ctrl_q.sub),
      .y   (y_c),
      .co  (co_c)
   );

   // Sign bits of the effective adder operands, used for overflow.
   assign a_msb_c = ctrl_q.ena & a_c[WORD_W-1];
   assign b_msb_c = ctrl_q.sub ^ din[WORD_W-1];

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_c) state_d = ST_RUN;
         ST_RUN:  if (last_c)  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs.
   always_comb begin
      din_rdy_d = (state_d == ST_RUN);
      busy_d    = (state_d != ST_IDLE);
      flg_vld_d = (state_d == ST_DONE);
      flags_d   = flags_q;
      if (last_c) begin
         flags_d[F_Z] = zacc_q & (y_c == '0);
         flags_d[F_N] = y_c[WORD_W-1];
         flags_d[F_C] = co_c;
         flags_d[F_V] = (a_msb_c == b_msb_c) & (y_c[WORD_W-1] != b_msb_c);
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         din_rdy_q <= 1'b0;
         busy_q    <= 1'b0;
         flg_vld_q <= 1'b0;
         flags_q   <= '0;
      end else begin
         din_rdy_q <= din_rdy_d;
         busy_q    <= busy_d;
         flg_vld_q <= flg_vld_d;
         flags_q   <= flags_d;
      end
   end

   // Operation context and inter-word state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ctrl_q  <= '0;
         last_q  <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         zacc_q  <= 1'b0;
      end else if (start_c) begin
         ctrl_q  <= op_to_ctrl(op);
         last_q  <= words;
         idx_q   <= '0;
         carry_q <= op_to_ctrl(op).sub;
         zacc_q  <= 1'b1;
      end else if (take_c) begin
         carry_q <= co_c;
         zacc_q  <= zacc_q & (y_c == '0);
         // Hold idx on the last word so it never wraps.
         if (!last_c) idx_q <= idx_q + IDX_W'(1);
      end
   end

   // Accumulator register file; words above the last index are untouched.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NWORDS; i++) acc_q[i] <= '0;
      end else if (take_c) begin
         acc_q[idx_q] <= y_c;
      end
   end

   assign rdata   = acc_q[raddr];
   assign din_rdy = din_rdy_q;
   assign busy    = busy_q;
   assign flg_vld = flg_vld_q;
   assign flags   = flags_q;

endmodule
